// File: rtl/ddr5_cmd_responder_pkg.sv
//------------------------------------------------------------------------------
// Package   : types_def
// Purpose   : Shared DDR5 responder types, CA opcode constants and burst length.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package types_def;

    localparam int data_width = 16;
    localparam int BURST_LEN  = 16;
    localparam int NUM_BANKS  = 16;

    localparam logic [1:0] CA_ACT = 2'b00;
    localparam logic [4:0] CA_RD  = 5'b11101;
    localparam logic [4:0] CA_WR  = 5'b01101;
    localparam logic [4:0] CA_PRE = 5'b11011;

    typedef enum logic [2:0] {
        OP_ACT,
        OP_RD,
        OP_WR,
        OP_PRE,
        OP_ILL
    } ddr5_op_e;

    // ACT owns the whole CA[1:0]=00 space, so it is tested before the 5-bit codes.
    function automatic ddr5_op_e decode_op(input logic [4:0] ca);
        if (ca[1:0] == CA_ACT)  return OP_ACT;
        else if (ca == CA_RD)   return OP_RD;
        else if (ca == CA_WR)   return OP_WR;
        else if (ca == CA_PRE)  return OP_PRE;
        else                    return OP_ILL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr5_cmd_responder_bank_table.sv
//------------------------------------------------------------------------------
// Module    : ddr5_bank_table
// Purpose   : 16-entry bank state (valid = ACTIVE) and open-row store.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr5_bank_table
    import types_def::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        act_i,
    input  logic        pre_i,
    input  logic [3:0]  upd_idx_i,
    input  logic [15:0] act_row_i,
    input  logic [3:0]  lk_idx_i,
    output logic        lk_valid_o,
    output logic [15:0] lk_row_o
);

    logic [NUM_BANKS-1:0] valid_q;
    logic [15:0]          row_q [NUM_BANKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else if (act_i) begin
            valid_q[upd_idx_i] <= 1'b1;
            row_q[upd_idx_i]   <= act_row_i;
        end else if (pre_i) begin
            valid_q[upd_idx_i] <= 1'b0;
        end
    end

    assign lk_valid_o = valid_q[lk_idx_i];
    assign lk_row_o   = row_q[lk_idx_i];

endmodule

`default_nettype wire

// File: rtl/ddr5_cmd_responder.sv
//------------------------------------------------------------------------------
// Module    : ddr5_cmd_responder
// Purpose   : DDR5 device-side command decoder, bank tracker and burst engine.
//             Optional macro DDR5_RSP_CHECK_EN enables the ALERT_n error pulse.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr5_cmd_responder
    import types_def::*;
#(
    parameter int DATA_W = data_width,
    parameter int RL     = 11,
    parameter int WL     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS_n,
    input  logic [13:0]       CA,
    input  logic [DATA_W-1:0] dq_in,
    input  logic [2:0]        dm_n,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              ALERT_n,
    output logic              mem_en,
    output logic              mem_we,
    output logic [29:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W  = 8;
    localparam int BEAT_W = $clog2(BURST_LEN);
    // Reads start issuing one cycle early to cover the 1-cycle memory latency.
    localparam logic [CNT_W-1:0] WAIT_RD = CNT_W'(RL - 3);
    localparam logic [CNT_W-1:0] WAIT_WR = CNT_W'(WL - 2);

    typedef enum logic {DEC_FIRST, DEC_SECOND} dec_e;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_BURST} dst_e;

    dec_e        dec_q, dec_d;
    ddr5_op_e    op_q, op_d;
    logic [3:0]  ba_q, ba_d;
    logic [3:0]  rowlo_q, rowlo_d;
    logic [15:0] row_q, row_d;
    logic        exec_q, exec_d;

    dst_e              dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              wr_q, wr_d;
    logic [5:0]        col_q, col_d;
    logic [3:0]        bba_q, bba_d;
    logic [15:0]       brow_q, brow_d;
    logic              dq_oe_q;

    logic        w_first;
    ddr5_op_e    w_op;
    logic        w_ok;
    logic        w_lk_valid;
    logic [15:0] w_lk_row;
    logic        w_exec2;
    logic        w_act_exec;
    logic        w_pre_exec;
    logic        w_start;
    logic [3:0]  w_upd_idx;
    logic        w_beat;
    logic        w_wr_ok;
    logic        w_ca_unused;

    assign w_ca_unused = ^CA[13:12];

    assign w_first = (dec_q == DEC_FIRST) && !CS_n;
    assign w_op    = decode_op(CA[4:0]);

    // All legality checks happen on the first cycle; the second cycle only executes.
    always_comb begin
        w_ok = 1'b0;
        case (w_op)
            OP_ACT:        w_ok = !w_lk_valid;
            OP_RD, OP_WR:  w_ok = w_lk_valid && (dst_q == D_IDLE);
            OP_PRE:        w_ok = 1'b1;
            default:       w_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_d   = dec_q;
        op_d    = op_q;
        ba_d    = ba_q;
        rowlo_d = rowlo_q;
        row_d   = row_q;
        exec_d  = exec_q;
        case (dec_q)
            DEC_FIRST: begin
                if (w_first && (w_op == OP_ACT || w_op == OP_RD || w_op == OP_WR)) begin
                    dec_d   = DEC_SECOND;
                    op_d    = w_op;
                    ba_d    = CA[10:7];
                    rowlo_d = CA[6:3];
                    row_d   = w_lk_row;
                    exec_d  = w_ok;
                end
            end
            DEC_SECOND: dec_d = DEC_FIRST;
            default:    dec_d = DEC_FIRST;
        endcase
    end

    assign w_exec2    = (dec_q == DEC_SECOND) && exec_q;
    assign w_act_exec = w_exec2 && (op_q == OP_ACT);
    assign w_start    = w_exec2 && (op_q == OP_RD || op_q == OP_WR);
    assign w_pre_exec = w_first && (w_op == OP_PRE);
    assign w_upd_idx  = w_act_exec ? ba_q : CA[10:7];

    ddr5_bank_table u_bank_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .act_i      (w_act_exec),
        .pre_i      (w_pre_exec),
        .upd_idx_i  (w_upd_idx),
        .act_row_i  ({CA[11:0], rowlo_q}),
        .lk_idx_i   (CA[10:7]),
        .lk_valid_o (w_lk_valid),
        .lk_row_o   (w_lk_row)
    );

    always_comb begin
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        wr_d   = wr_q;
        col_d  = col_q;
        bba_d  = bba_q;
        brow_d = brow_q;
        case (dst_q)
            D_IDLE: begin
                if (w_start) begin
                    dst_d  = D_WAIT;
                    wr_d   = (op_q == OP_WR);
                    col_d  = (op_q == OP_WR) ? CA[6:1] : CA[7:2];
                    cnt_d  = (op_q == OP_WR) ? WAIT_WR : WAIT_RD;
                    bba_d  = ba_q;
                    brow_d = row_q;
                    beat_d = '0;
                end
            end
            D_WAIT: begin
                if (cnt_q == '0) dst_d = D_BURST;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            D_BURST: begin
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    dst_d  = D_IDLE;
                    beat_d = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: dst_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= DEC_FIRST;
            op_q    <= OP_ACT;
            ba_q    <= '0;
            rowlo_q <= '0;
            row_q   <= '0;
            exec_q  <= 1'b0;
            dst_q   <= D_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            wr_q    <= 1'b0;
            col_q   <= '0;
            bba_q   <= '0;
            brow_q  <= '0;
            dq_oe_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            op_q    <= op_d;
            ba_q    <= ba_d;
            rowlo_q <= rowlo_d;
            row_q   <= row_d;
            exec_q  <= exec_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
            col_q   <= col_d;
            bba_q   <= bba_d;
            brow_q  <= brow_d;
            dq_oe_q <= w_beat && !wr_q;
        end
    end

    assign w_beat    = (dst_q == D_BURST);
    assign w_wr_ok   = (dm_n == 3'b111);
    assign mem_en    = w_beat && (!wr_q || w_wr_ok);
    assign mem_we    = w_beat && wr_q && w_wr_ok;
    assign mem_addr  = w_beat ? {bba_q, brow_q, col_q, beat_q} : '0;
    assign mem_wdata = (w_beat && wr_q) ? dq_in : '0;
    assign dq_oe     = dq_oe_q;
    assign dq_out    = dq_oe_q ? mem_rdata : '0;

`ifdef DDR5_RSP_CHECK_EN
    logic [1:0] alert_q;
    logic       w_err;

    assign w_err = w_first && !w_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alert_q <= '0;
        else        alert_q <= {alert_q[0], w_err};
    end

    assign ALERT_n = !alert_q[1];
`else
    assign ALERT_n = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr5_cmd_responder.sv
//------------------------------------------------------------------------------
// Module    : tb_ddr5_cmd_responder
// Purpose   : Directed, table-driven self-checking bench for ddr5_cmd_responder.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr5_cmd_responder;

    localparam int RL = 11;
    localparam int WL = 8;
    localparam int DW = 16;

    localparam int K_NONE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;

    localparam int C_ACT = 0;
    localparam int C_RD  = 1;
    localparam int C_WR  = 2;
    localparam int C_PRE = 3;
    localparam int C_ILL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          CS_n;
    logic [13:0]   CA;
    logic [DW-1:0] dq_in;
    logic [2:0]    dm_n;
    logic [DW-1:0] dq_out;
    logic          dq_oe;
    logic          ALERT_n;
    logic          mem_en;
    logic          mem_we;
    logic [29:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    ddr5_cmd_responder #(.DATA_W(DW), .RL(RL), .WL(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CS_n      (CS_n),
        .CA        (CA),
        .dq_in     (dq_in),
        .dm_n      (dm_n),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .ALERT_n   (ALERT_n),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input logic [29:0] a);
        return a[15:0] ^ 16'hA55A ^ {a[29:26], 12'h000};
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
        else                   mem_rdata <= '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic enc(input int op, input logic [3:0] ba, input logic [15:0] row,
                       input logic [5:0] col, output logic [13:0] c1,
                       output logic [13:0] c2, output bit two);
        c1 = '0; c2 = '0; two = 1'b1;
        c1[10:7] = ba;
        case (op)
            C_ACT: begin c1[1:0] = 2'b00; c1[6:3] = row[3:0]; c2[11:0] = row[15:4]; end
            C_RD:  begin c1[4:0] = 5'b11101; c2[7:2] = col; end
            C_WR:  begin c1[4:0] = 5'b01101; c2[6:1] = col; end
            C_PRE: begin c1[4:0] = 5'b11011; two = 1'b0; end
            default: begin c1[4:0] = 5'b00001; two = 1'b0; end
        endcase
    endtask

    // Leaves the bench 2ns after the edge that sampled the command's last cycle.
    task automatic send(input int op, input logic [3:0] ba, input logic [15:0] row,
                        input logic [5:0] col);
        logic [13:0] c1, c2;
        bit two;
        enc(op, ba, row, col, c1, c2, two);
        CS_n = 1'b0; CA = c1;
        @(posedge clk); #2;
        CS_n = 1'b1; CA = two ? c2 : 14'h0;
        if (two) begin
            @(posedge clk); #2;
            CA = 14'h0;
        end
    endtask

    // Cycle j of the window is the j-th cycle after the command's last sampled cycle.
    task automatic check_window(input int kind, input logic [3:0] ba, input logic [15:0] row,
                                input logic [5:0] col, input int mask, input int alert_j,
                                input int ncyc, input int inj_j, input int inj_op,
                                input logic [3:0] inj_ba, input logic [5:0] inj_col);
        logic [13:0] i1, i2;
        bit          itwo;
        logic [29:0] ea;
        logic        exp_en, exp_we, exp_oe, exp_al;
        int          b_rd, b_dq, b_wr;
        enc(inj_op, inj_ba, 16'h0, inj_col, i1, i2, itwo);
        for (int j = 1; j <= ncyc; j++) begin
            if (inj_j > 0 && j == inj_j) begin
                CS_n = 1'b0; CA = i1;
            end else if (inj_j > 0 && j == inj_j + 1) begin
                CS_n = 1'b1; CA = itwo ? i2 : 14'h0;
            end else begin
                CS_n = 1'b1; CA = 14'h0;
            end
            b_rd = j - (RL - 1);
            b_dq = j - RL;
            b_wr = j - WL;
            dq_in = 16'h1000 + 16'(j);
            dm_n  = (kind == K_WR && b_wr == mask) ? 3'b011 : 3'b111;
            exp_en = 1'b0; exp_we = 1'b0; exp_oe = 1'b0; ea = '0;
            if (kind == K_RD && b_rd >= 0 && b_rd < 16) begin
                exp_en = 1'b1; ea = {ba, row, col, 4'(b_rd)};
            end
            if (kind == K_WR && b_wr >= 0 && b_wr < 16 && b_wr != mask) begin
                exp_en = 1'b1; exp_we = 1'b1; ea = {ba, row, col, 4'(b_wr)};
            end
            if (kind == K_RD && b_dq >= 0 && b_dq < 16) exp_oe = 1'b1;
`ifdef DDR5_RSP_CHECK_EN
            exp_al = (j == alert_j) ? 1'b0 : 1'b1;
`else
            exp_al = 1'b1;
`endif
            @(negedge clk);
            chk("mem_en", 32'(mem_en), 32'(exp_en));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("dq_oe", 32'(dq_oe), 32'(exp_oe));
            chk("ALERT_n", 32'(ALERT_n), 32'(exp_al));
            if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(ea));
            if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(16'h1000 + 16'(j)));
            if (exp_oe) chk("dq_out", 32'(dq_out), 32'(mem_val({ba, row, col, 4'(b_dq)})));
            @(posedge clk); #2;
        end
        CS_n = 1'b1; CA = 14'h0;
    endtask

    typedef struct {
        int          op;
        logic [3:0]  ba;
        logic [15:0] row;
        logic [5:0]  col;
        int          kind;
        int          mask;
        int          alert_j;
        int          ncyc;
        int          inj_j;
        int          inj_op;
        logic [3:0]  inj_ba;
        logic [5:0]  inj_col;
    } vec_t;

    function automatic vec_t mk(input int op, input logic [3:0] ba, input logic [15:0] row,
                                input logic [5:0] col, input int kind, input int mask,
                                input int alert_j, input int ncyc, input int inj_j,
                                input int inj_op, input logic [3:0] inj_ba,
                                input logic [5:0] inj_col);
        vec_t v;
        v.op = op; v.ba = ba; v.row = row; v.col = col; v.kind = kind; v.mask = mask;
        v.alert_j = alert_j; v.ncyc = ncyc; v.inj_j = inj_j; v.inj_op = inj_op;
        v.inj_ba = inj_ba; v.inj_col = inj_col;
        return v;
    endfunction

    vec_t vt [14];

    initial begin
        // bg=1 bank=2 is table index 6; an injected RD in the burst must be dropped.
        vt[0]  = mk(C_ACT, 4'd6,  16'hABCD, 6'd0,  K_NONE, -1, -1, 2,       0,  C_ILL, 4'd0,  6'd0);
        vt[1]  = mk(C_RD,  4'd6,  16'hABCD, 6'd5,  K_RD,   -1, 16, RL + 17, 14, C_RD,  4'd6,  6'd9);
        vt[2]  = mk(C_RD,  4'd3,  16'h0000, 6'd0,  K_NONE, -1, 1,  4,       0,  C_ILL, 4'd0,  6'd0);
        vt[3]  = mk(C_ACT, 4'd6,  16'h1111, 6'd0,  K_NONE, -1, 1,  4,       0,  C_ILL, 4'd0,  6'd0);
        vt[4]  = mk(C_PRE, 4'd6,  16'h0000, 6'd0,  K_NONE, -1, -1, 3,       0,  C_ILL, 4'd0,  6'd0);
        vt[5]  = mk(C_RD,  4'd6,  16'h0000, 6'd0,  K_NONE, -1, 1,  4,       0,  C_ILL, 4'd0,  6'd0);
        vt[6]  = mk(C_PRE, 4'd6,  16'h0000, 6'd0,  K_NONE, -1, -1, 4,       0,  C_ILL, 4'd0,  6'd0);
        vt[7]  = mk(C_ILL, 4'd0,  16'h0000, 6'd0,  K_NONE, -1, 2,  4,       0,  C_ILL, 4'd0,  6'd0);
        vt[8]  = mk(C_ACT, 4'd9,  16'h1234, 6'd0,  K_NONE, -1, -1, 2,       0,  C_ILL, 4'd0,  6'd0);
        vt[9]  = mk(C_WR,  4'd9,  16'h1234, 6'd3,  K_WR,   4,  -1, WL + 17, 0,  C_ILL, 4'd0,  6'd0);
        vt[10] = mk(C_ACT, 4'd15, 16'hFFFF, 6'd0,  K_NONE, -1, -1, 2,       0,  C_ILL, 4'd0,  6'd0);
        // PRE to the bursting bank mid-burst: burst finishes on the stored row.
        vt[11] = mk(C_RD,  4'd15, 16'hFFFF, 6'd63, K_RD,   -1, -1, RL + 17, 12, C_PRE, 4'd15, 6'd0);
        vt[12] = mk(C_RD,  4'd15, 16'h0000, 6'd0,  K_NONE, -1, 1,  4,       0,  C_ILL, 4'd0,  6'd0);
        vt[13] = mk(C_WR,  4'd9,  16'h1234, 6'd0,  K_WR,   -1, -1, WL + 17, 0,  C_ILL, 4'd0,  6'd0);

        rst_n = 1'b0; CS_n = 1'b1; CA = '0; dq_in = '0; dm_n = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_dq_out", 32'(dq_out), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_ALERT_n", 32'(ALERT_n), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #2; end

        for (int i = 0; i < 14; i++) begin
            send(vt[i].op, vt[i].ba, vt[i].row, vt[i].col);
            check_window(vt[i].kind, vt[i].ba, vt[i].row, vt[i].col, vt[i].mask,
                         vt[i].alert_j, vt[i].ncyc, vt[i].inj_j, vt[i].inj_op,
                         vt[i].inj_ba, vt[i].inj_col);
        end

        // Reset asserted during the read-beat-7 cycle.
        send(C_ACT, 4'd2, 16'h0F0F, 6'd0);
        check_window(K_NONE, 4'd2, 16'h0F0F, 6'd0, -1, -1, 2, 0, C_ILL, 4'd0, 6'd0);
        send(C_RD, 4'd2, 16'h0F0F, 6'd1);
        check_window(K_RD, 4'd2, 16'h0F0F, 6'd1, -1, -1, RL + 6, 0, C_ILL, 4'd0, 6'd0);
        chk("pre_rst_dq_oe", 32'(dq_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("async_rst_mem_en", 32'(mem_en), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_dq_out", 32'(dq_out), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("in_rst_mem_en", 32'(mem_en), 32'd0);
            chk("in_rst_dq_oe", 32'(dq_oe), 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        check_window(K_NONE, 4'd0, 16'h0, 6'd0, -1, -1, 20, 0, C_ILL, 4'd0, 6'd0);
        send(C_RD, 4'd2, 16'h0F0F, 6'd1);
        check_window(K_NONE, 4'd2, 16'h0F0F, 6'd1, -1, 1, RL + 17, 0, C_ILL, 4'd0, 6'd0);
        send(C_WR, 4'd9, 16'h1234, 6'd0);
        check_window(K_NONE, 4'd9, 16'h1234, 6'd0, -1, 1, WL + 17, 0, C_ILL, 4'd0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
